// File: rtl/sdspi_cmd_responder.sv
// sdspi_cmd_responder
// Card-side SPI-mode SD command path. Parses the 6-byte command frames the
// host shifts in on MOSI and checks CRC7 and the end bit. It hands the decoded
// command to the card logic, then shifts out the R1 / R1b / R3-R7 response on MISO.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_ll_sel            chip select (active-high, synchronised)
//   i_ll_stb/i_ll_byte  byte-exchange-complete pulse and received MOSI byte
//   o_ll_byte           byte for the next MISO exchange (registered)
//   o_busy              frame or response in progress
//   o_cmd_stb/o_cmd/o_cmd_arg  decoded command pulse, index, argument
//   o_crc_err           frame rejected for CRC or end bit
//   i_idle              card in-idle flag, used in the autonomous CRC-error R1
//   i_rsp_stb/i_rsp_type/i_rsp_r1/i_rsp_data  response request from the app
//   i_card_busy         busy indication for R1b
module sdspi_cmd_responder #(
    parameter bit OPT_CRC_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ll_sel,
    input  logic        i_ll_stb,
    input  logic [7:0]  i_ll_byte,
    output logic [7:0]  o_ll_byte,
    output logic        o_busy,
    output logic        o_cmd_stb,
    output logic [5:0]  o_cmd,
    output logic [31:0] o_cmd_arg,
    output logic        o_crc_err,
    input  logic        i_idle,
    input  logic        i_rsp_stb,
    input  logic [1:0]  i_rsp_type,
    input  logic [7:0]  i_rsp_r1,
    input  logic [31:0] i_rsp_data,
    input  logic        i_card_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RXCMD = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_BUSY  = 3'd4
    } state_t;

    // CRC7 (x^7 + x^3 + 1), MSB first, advanced by one whole byte.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
        end
        return c;
    endfunction

    state_t      state_r, state_nx_s;
    logic [2:0]  byte_cnt_r, byte_cnt_nx_s;
    logic [2:0]  send_cnt_r, send_cnt_nx_s;
    logic [6:0]  crc_r, crc_nx_s;
    logic [5:0]  cmd_r, cmd_nx_s;
    logic [31:0] arg_r, arg_nx_s;
    logic [7:0]  ll_byte_r, ll_byte_nx_s;
    logic        busy_r;
    logic        cmd_stb_r, cmd_stb_nx_s;
    logic        crc_err_r, crc_err_nx_s;
    logic        pend_r, pend_nx_s;
    logic [1:0]  rsp_type_r, rsp_type_nx_s;
    logic [7:0]  rsp_r1_r, rsp_r1_nx_s;
    logic [31:0] rsp_data_r, rsp_data_nx_s;
    logic        frame_ok_s;

    // Last byte must be {crc7, end bit}; CRC checking can be compiled out.
    assign frame_ok_s = (i_ll_byte == {crc_r, 1'b1}) || (OPT_CRC_CHECK == 1'b0);

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 3'd0;
            send_cnt_r <= 3'd0;
            crc_r      <= 7'd0;
            cmd_r      <= 6'd0;
            arg_r      <= 32'd0;
            ll_byte_r  <= 8'hFF;
            busy_r     <= 1'b0;
            cmd_stb_r  <= 1'b0;
            crc_err_r  <= 1'b0;
            pend_r     <= 1'b0;
            rsp_type_r <= 2'b00;
            rsp_r1_r   <= 8'h00;
            rsp_data_r <= 32'd0;
        end else begin
            state_r    <= state_nx_s;
            byte_cnt_r <= byte_cnt_nx_s;
            send_cnt_r <= send_cnt_nx_s;
            crc_r      <= crc_nx_s;
            cmd_r      <= cmd_nx_s;
            arg_r      <= arg_nx_s;
            ll_byte_r  <= ll_byte_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
            cmd_stb_r  <= cmd_stb_nx_s;
            crc_err_r  <= crc_err_nx_s;
            pend_r     <= pend_nx_s;
            rsp_type_r <= rsp_type_nx_s;
            rsp_r1_r   <= rsp_r1_nx_s;
            rsp_data_r <= rsp_data_nx_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s    = state_r;
        byte_cnt_nx_s = byte_cnt_r;
        send_cnt_nx_s = send_cnt_r;
        crc_nx_s      = crc_r;
        cmd_nx_s      = cmd_r;
        arg_nx_s      = arg_r;
        ll_byte_nx_s  = ll_byte_r;
        cmd_stb_nx_s  = 1'b0;
        crc_err_nx_s  = 1'b0;
        pend_nx_s     = pend_r;
        rsp_type_nx_s = rsp_type_r;
        rsp_r1_nx_s   = rsp_r1_r;
        rsp_data_nx_s = rsp_data_r;

        if (!i_ll_sel) begin
            // Deselect aborts whatever is in flight, including a pending response.
            state_nx_s   = ST_IDLE;
            ll_byte_nx_s = 8'hFF;
            pend_nx_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_ll_stb && (i_ll_byte[7:6] == 2'b01)) begin
                        cmd_nx_s      = i_ll_byte[5:0];
                        crc_nx_s      = crc7_byte(7'd0, i_ll_byte);
                        byte_cnt_nx_s = 3'd5;
                        pend_nx_s     = 1'b0;
                        state_nx_s    = ST_RXCMD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RXCMD: begin
                    if (i_ll_stb) begin
                        if (byte_cnt_r != 3'd1) begin
                            arg_nx_s      = {arg_r[23:0], i_ll_byte};
                            crc_nx_s      = crc7_byte(crc_r, i_ll_byte);
                            byte_cnt_nx_s = byte_cnt_r - 3'd1;
                        end else begin
                            // CRC byte: the following exchange always returns FF.
                            ll_byte_nx_s = 8'hFF;
                            state_nx_s   = ST_WAIT;
                            if (frame_ok_s) begin
                                cmd_stb_nx_s = 1'b1;
                                pend_nx_s    = 1'b0;
                            end else begin
                                // Autonomous R1 with the CRC-error bit set.
                                crc_err_nx_s  = 1'b1;
                                pend_nx_s     = 1'b1;
                                rsp_type_nx_s = 2'b00;
                                rsp_r1_nx_s   = {4'b0000, 1'b1, 2'b00, i_idle};
                            end
                        end
                    end else begin
                        state_nx_s = ST_RXCMD;
                    end
                end
                ST_WAIT: begin
                    if (i_rsp_stb && !pend_r) begin
                        rsp_type_nx_s = i_rsp_type;
                        rsp_r1_nx_s   = i_rsp_r1 & 8'h7F;
                        rsp_data_nx_s = i_rsp_data;
                        pend_nx_s     = 1'b1;
                    end else begin
                        pend_nx_s = pend_r;
                    end
                    // A request arriving with the strobe counts as already pending.
                    if (i_ll_stb && (pend_r || i_rsp_stb)) begin
                        if (pend_r) begin
                            ll_byte_nx_s = rsp_r1_r;
                        end else begin
                            ll_byte_nx_s = i_rsp_r1 & 8'h7F;
                        end
                        pend_nx_s     = 1'b0;
                        send_cnt_nx_s = 3'd0;
                        state_nx_s    = ST_SEND;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_SEND: begin
                    if (i_ll_stb) begin
                        if (rsp_type_r[1] && (send_cnt_r != 3'd4)) begin
                            // Payload goes out MSB first by shifting the latched word.
                            ll_byte_nx_s  = rsp_data_r[31:24];
                            rsp_data_nx_s = {rsp_data_r[23:0], 8'h00};
                            send_cnt_nx_s = send_cnt_r + 3'd1;
                        end else if ((rsp_type_r == 2'b01) && i_card_busy) begin
                            ll_byte_nx_s = 8'h00;
                            state_nx_s   = ST_BUSY;
                        end else begin
                            ll_byte_nx_s = 8'hFF;
                            state_nx_s   = ST_IDLE;
                        end
                    end else begin
                        state_nx_s = ST_SEND;
                    end
                end
                ST_BUSY: begin
                    if (i_ll_stb) begin
                        if (i_card_busy) begin
                            ll_byte_nx_s = 8'h00;
                        end else begin
                            ll_byte_nx_s = 8'hFF;
                            state_nx_s   = ST_IDLE;
                        end
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    ll_byte_nx_s = 8'hFF;
                    pend_nx_s    = 1'b0;
                end
            endcase
        end
    end

    assign o_ll_byte = ll_byte_r;
    assign o_busy    = busy_r;
    assign o_cmd_stb = cmd_stb_r;
    assign o_cmd     = cmd_r;
    assign o_cmd_arg = arg_r;
    assign o_crc_err = crc_err_r;

endmodule

// File: tb/tb_sdspi_cmd_responder.sv
// Directed bench for sdspi_cmd_responder. Instance a checks CRC, instance b
// is built with CRC checking disabled; both see identical stimulus.
module tb_sdspi_cmd_responder;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ll_sel = 1'b0;
    logic        i_ll_stb = 1'b0;
    logic [7:0]  i_ll_byte = 8'h00;
    logic        i_idle = 1'b0;
    logic        i_rsp_stb = 1'b0;
    logic [1:0]  i_rsp_type = 2'b00;
    logic [7:0]  i_rsp_r1 = 8'h00;
    logic [31:0] i_rsp_data = 32'd0;
    logic        i_card_busy = 1'b0;

    logic [7:0]  a_ll_byte, b_ll_byte;
    logic        a_busy, b_busy, a_cmd_stb, b_cmd_stb, a_crc_err, b_crc_err;
    logic [5:0]  a_cmd, b_cmd;
    logic [31:0] a_arg, b_arg;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int n_cmd_a = 0, n_err_a = 0, n_cmd_b = 0;

    sdspi_cmd_responder #(.OPT_CRC_CHECK(1'b1)) dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_ll_sel(i_ll_sel), .i_ll_stb(i_ll_stb),
        .i_ll_byte(i_ll_byte), .o_ll_byte(a_ll_byte), .o_busy(a_busy),
        .o_cmd_stb(a_cmd_stb), .o_cmd(a_cmd), .o_cmd_arg(a_arg), .o_crc_err(a_crc_err),
        .i_idle(i_idle), .i_rsp_stb(i_rsp_stb), .i_rsp_type(i_rsp_type),
        .i_rsp_r1(i_rsp_r1), .i_rsp_data(i_rsp_data), .i_card_busy(i_card_busy));

    sdspi_cmd_responder #(.OPT_CRC_CHECK(1'b0)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_ll_sel(i_ll_sel), .i_ll_stb(i_ll_stb),
        .i_ll_byte(i_ll_byte), .o_ll_byte(b_ll_byte), .o_busy(b_busy),
        .o_cmd_stb(b_cmd_stb), .o_cmd(b_cmd), .o_cmd_arg(b_arg), .o_crc_err(b_crc_err),
        .i_idle(i_idle), .i_rsp_stb(i_rsp_stb), .i_rsp_type(i_rsp_type),
        .i_rsp_r1(i_rsp_r1), .i_rsp_data(i_rsp_data), .i_card_busy(i_card_busy));

    always #5 i_clk = ~i_clk;

    // Pulse counters, so missing or extra strobes show up.
    always @(posedge i_clk) begin
        if (a_cmd_stb) n_cmd_a <= n_cmd_a + 1;
        if (a_crc_err) n_err_a <= n_err_a + 1;
        if (b_cmd_stb) n_cmd_b <= n_cmd_b + 1;
    end

    task automatic exch(input logic [7:0] b, input bit with_rsp);
        @(negedge i_clk);
        i_ll_byte = b;
        i_ll_stb  = 1'b1;
        i_rsp_stb = with_rsp;
        @(negedge i_clk);
        i_ll_stb  = 1'b0;
        i_rsp_stb = 1'b0;
    endtask

    task automatic frame(input logic [7:0] c, input logic [31:0] arg, input logic [7:0] crc);
        exch(c, 1'b0);
        exch(arg[31:24], 1'b0);
        exch(arg[23:16], 1'b0);
        exch(arg[15:8], 1'b0);
        exch(arg[7:0], 1'b0);
        exch(crc, 1'b0);
    endtask

    task automatic respond(input logic [1:0] t, input logic [7:0] r1, input logic [31:0] d);
        i_rsp_type = t;
        i_rsp_r1   = r1;
        i_rsp_data = d;
        i_rsp_stb  = 1'b1;
        @(negedge i_clk);
        i_rsp_stb  = 1'b0;
    endtask

    task automatic sel_pulse();
        @(negedge i_clk);
        i_ll_sel = 1'b0;
        @(negedge i_clk);
        i_ll_sel = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL reset_ll_byte: got %h want ff", a_ll_byte); else pass_cnt++;
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else pass_cnt++;
        total_cnt++; if (a_cmd_stb !== 1'b0) $display("FAIL reset_cmd_stb: got %b want 0", a_cmd_stb); else pass_cnt++;
        total_cnt++; if (a_crc_err !== 1'b0) $display("FAIL reset_crc_err: got %b want 0", a_crc_err); else pass_cnt++;
        total_cnt++; if (a_cmd !== 6'd0) $display("FAIL reset_cmd: got %h want 00", a_cmd); else pass_cnt++;
        total_cnt++; if (a_arg !== 32'd0) $display("FAIL reset_arg: got %h want 0", a_arg); else pass_cnt++;
        i_reset = 1'b0;
        i_ll_sel = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_cmd0_r1();
        frame(8'h40, 32'h0000_0000, 8'h95);
        total_cnt++; if (a_cmd_stb !== 1'b1) $display("FAIL cmd0_stb: got %b want 1", a_cmd_stb); else pass_cnt++;
        total_cnt++; if (a_cmd !== 6'd0) $display("FAIL cmd0_cmd: got %h want 00", a_cmd); else pass_cnt++;
        total_cnt++; if (a_arg !== 32'd0) $display("FAIL cmd0_arg: got %h want 0", a_arg); else pass_cnt++;
        total_cnt++; if (a_crc_err !== 1'b0) $display("FAIL cmd0_crc_err: got %b want 0", a_crc_err); else pass_cnt++;
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL cmd0_ncr: got %h want ff", a_ll_byte); else pass_cnt++;
        total_cnt++; if (a_busy !== 1'b1) $display("FAIL cmd0_busy: got %b want 1", a_busy); else pass_cnt++;
        respond(2'b00, 8'h01, 32'd0);
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'h01) $display("FAIL cmd0_r1: got %h want 01", a_ll_byte); else pass_cnt++;
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL cmd0_end: got %h want ff", a_ll_byte); else pass_cnt++;
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL cmd0_idle: got %b want 0", a_busy); else pass_cnt++;
    endtask

    task automatic test_cmd8_r7();
        logic [7:0] exp_seq [6] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hFF};
        frame(8'h48, 32'h0000_01AA, 8'h87);
        total_cnt++; if (a_cmd_stb !== 1'b1) $display("FAIL cmd8_stb: got %b want 1", a_cmd_stb); else pass_cnt++;
        total_cnt++; if (a_cmd !== 6'd8) $display("FAIL cmd8_cmd: got %h want 08", a_cmd); else pass_cnt++;
        total_cnt++; if (a_arg !== 32'h0000_01AA) $display("FAIL cmd8_arg: got %h want 000001aa", a_arg); else pass_cnt++;
        respond(2'b10, 8'h01, 32'h0000_01AA);
        for (int i = 0; i < 6; i++) begin
            exch(8'hFF, 1'b0);
            total_cnt++;
            if (a_ll_byte !== exp_seq[i]) $display("FAIL cmd8_miso[%0d]: got %h want %h", i, a_ll_byte, exp_seq[i]);
            else pass_cnt++;
        end
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL cmd8_idle: got %b want 0", a_busy); else pass_cnt++;
    endtask

    task automatic test_crc_error();
        int ca, ea, cb;
        ca = n_cmd_a; ea = n_err_a; cb = n_cmd_b;
        i_idle = 1'b1;
        frame(8'h40, 32'h0000_0000, 8'h94);
        total_cnt++; if (a_crc_err !== 1'b1) $display("FAIL crcerr_pulse: got %b want 1", a_crc_err); else pass_cnt++;
        total_cnt++; if (a_cmd_stb !== 1'b0) $display("FAIL crcerr_no_stb: got %b want 0", a_cmd_stb); else pass_cnt++;
        total_cnt++; if (b_cmd_stb !== 1'b1) $display("FAIL nocheck_stb: got %b want 1", b_cmd_stb); else pass_cnt++;
        total_cnt++; if (b_crc_err !== 1'b0) $display("FAIL nocheck_no_err: got %b want 0", b_crc_err); else pass_cnt++;
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL crcerr_ncr: got %h want ff", a_ll_byte); else pass_cnt++;
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'h09) $display("FAIL crcerr_r1: got %h want 09", a_ll_byte); else pass_cnt++;
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL crcerr_end: got %h want ff", a_ll_byte); else pass_cnt++;
        total_cnt++; if (n_cmd_a !== ca) $display("FAIL crcerr_stb_count: got %0d want %0d", n_cmd_a, ca); else pass_cnt++;
        total_cnt++; if (n_err_a !== ea + 1) $display("FAIL crcerr_err_count: got %0d want %0d", n_err_a, ea + 1); else pass_cnt++;
        total_cnt++; if (n_cmd_b !== cb + 1) $display("FAIL nocheck_stb_count: got %0d want %0d", n_cmd_b, cb + 1); else pass_cnt++;
        i_idle = 1'b0;
        sel_pulse();
    endtask

    task automatic test_r1b_busy();
        logic [7:0] exp_seq [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
        frame(8'h40, 32'h0000_0000, 8'h95);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL r1b_ncr: got %h want ff", a_ll_byte); else pass_cnt++;
        i_card_busy = 1'b1;
        i_rsp_type  = 2'b01;
        i_rsp_r1    = 8'h81;
        i_rsp_data  = 32'd0;
        // Request coincides with the exchange strobe; bit 7 of r1 is dropped.
        for (int i = 0; i < 4; i++) begin
            exch(8'hFF, (i == 0));
            total_cnt++;
            if (a_ll_byte !== exp_seq[i]) $display("FAIL r1b_miso[%0d]: got %h want %h", i, a_ll_byte, exp_seq[i]);
            else pass_cnt++;
        end
        total_cnt++; if (a_busy !== 1'b1) $display("FAIL r1b_busy_hold: got %b want 1", a_busy); else pass_cnt++;
        i_card_busy = 1'b0;
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL r1b_release: got %h want ff", a_ll_byte); else pass_cnt++;
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL r1b_idle: got %b want 0", a_busy); else pass_cnt++;
    endtask

    task automatic test_leading_bytes();
        logic [7:0] junk [3] = '{8'hFF, 8'h3F, 8'h80};
        for (int i = 0; i < 3; i++) begin
            exch(junk[i], 1'b0);
            total_cnt++;
            if (a_busy !== 1'b0) $display("FAIL lead_ignored[%0d]: got busy %b want 0", i, a_busy);
            else pass_cnt++;
        end
        frame(8'h51, 32'h0000_1000, 8'h27);
        total_cnt++; if (a_cmd_stb !== 1'b1) $display("FAIL cmd17_stb: got %b want 1", a_cmd_stb); else pass_cnt++;
        total_cnt++; if (a_cmd !== 6'd17) $display("FAIL cmd17_cmd: got %0d want 17", a_cmd); else pass_cnt++;
        total_cnt++; if (a_arg !== 32'h0000_1000) $display("FAIL cmd17_arg: got %h want 00001000", a_arg); else pass_cnt++;
        respond(2'b00, 8'h00, 32'd0);
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'h00) $display("FAIL cmd17_r1: got %h want 00", a_ll_byte); else pass_cnt++;
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL cmd17_end: got %h want ff", a_ll_byte); else pass_cnt++;
    endtask

    task automatic test_abort();
        int ca;
        ca = n_cmd_a;
        exch(8'h40, 1'b0);
        exch(8'h00, 1'b0);
        exch(8'h00, 1'b0);
        total_cnt++; if (a_busy !== 1'b1) $display("FAIL abort_rx_busy: got %b want 1", a_busy); else pass_cnt++;
        sel_pulse();
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL abort_rx_idle: got %b want 0", a_busy); else pass_cnt++;
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL abort_rx_ll: got %h want ff", a_ll_byte); else pass_cnt++;
        frame(8'h40, 32'h0000_0000, 8'h95);
        total_cnt++; if (a_cmd_stb !== 1'b1) $display("FAIL abort_next_stb: got %b want 1", a_cmd_stb); else pass_cnt++;
        // Abort while waiting for the application; the late request is dropped.
        sel_pulse();
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL abort_wait_idle: got %b want 0", a_busy); else pass_cnt++;
        respond(2'b00, 8'h01, 32'd0);
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL abort_wait_miso0: got %h want ff", a_ll_byte); else pass_cnt++;
        exch(8'hFF, 1'b0);
        total_cnt++; if (a_ll_byte !== 8'hFF) $display("FAIL abort_wait_miso1: got %h want ff", a_ll_byte); else pass_cnt++;
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL abort_wait_busy: got %b want 0", a_busy); else pass_cnt++;
        total_cnt++; if (n_cmd_a !== ca + 1) $display("FAIL abort_stb_count: got %0d want %0d", n_cmd_a, ca + 1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cmd0_r1();
        test_cmd8_r7();
        test_crc_error();
        test_r1b_busy();
        test_leading_bytes();
        test_abort();
        repeat (2) @(negedge i_clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
